// File: rtl/multdiv_sched.sv
`default_nettype none
// ============================================================================
// Module   : multdiv_sched
// Purpose  : Issue and writeback controller for the shared multiply/divide
//            unit. Latches one op, pulses the unit start, stalls dependent
//            decode, and writes the result (or an rstatus code to r30) into
//            free register-file write-port cycles.
// Revision : 1.0 - initial release
// ============================================================================
module multdiv_sched #(
  parameter int TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic        issue_is_mult,
  input  logic [4:0]  issue_rd,
  input  logic [31:0] issue_a,
  input  logic [31:0] issue_b,
  input  logic [4:0]  dec_rs,
  input  logic [4:0]  dec_rt,
  input  logic [4:0]  dec_rd,
  input  logic        dec_writes,
  output logic        stall,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  input  logic [31:0] md_result,
  input  logic        md_ready,
  input  logic        md_exception,
  input  logic        wb_pipe_valid,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_data,
  output logic        busy
);

  // Watchdog must be able to hold TIMEOUT-1, the value seen in the last RUN cycle.
  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  localparam logic [4:0]  EXC_RD       = 5'd30;
  localparam logic [31:0] EXC_CODE_MUL = 32'd4;
  localparam logic [31:0] EXC_CODE_DIV = 32'd5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_WB    = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [4:0]      pend_rd_q, pend_rd_d;
  logic            pend_mult_q, pend_mult_d;
  logic [31:0]     res_q, res_d;
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;
  logic [WDW-1:0]  wd_q, wd_d;
  logic            ctrl_mult_q, ctrl_mult_d;
  logic            ctrl_div_q, ctrl_div_d;

  logic            w_busy;
  logic            w_hazard;
  logic [31:0]     w_exc_code;

  // State and datapath registers; reset drops any pending op.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      pend_rd_q   <= 5'd0;
      pend_mult_q <= 1'b0;
      res_q       <= 32'd0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      wd_q        <= '0;
      ctrl_mult_q <= 1'b0;
      ctrl_div_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_rd_q   <= pend_rd_d;
      pend_mult_q <= pend_mult_d;
      res_q       <= res_d;
      a_q         <= a_d;
      b_q         <= b_d;
      wd_q        <= wd_d;
      ctrl_mult_q <= ctrl_mult_d;
      ctrl_div_q  <= ctrl_div_d;
    end
  end

  assign w_exc_code = pend_mult_q ? EXC_CODE_MUL : EXC_CODE_DIV;

  // Next-state logic; the start pulse is registered so it lines up with START.
  always_comb begin
    state_d     = state_q;
    pend_rd_d   = pend_rd_q;
    pend_mult_d = pend_mult_q;
    res_d       = res_q;
    a_d         = a_q;
    b_d         = b_q;
    wd_d        = wd_q;
    ctrl_mult_d = 1'b0;
    ctrl_div_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (issue_valid) begin
          a_d         = issue_a;
          b_d         = issue_b;
          pend_rd_d   = issue_rd;
          pend_mult_d = issue_is_mult;
          ctrl_mult_d = issue_is_mult;
          ctrl_div_d  = ~issue_is_mult;
          state_d     = S_START;
        end
      end
      S_START: begin
        // md_ready is deliberately not looked at here.
        wd_d    = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        wd_d = wd_q + WDW'(1);
        if (md_ready) begin
          if (md_exception) begin
            res_d     = w_exc_code;
            pend_rd_d = EXC_RD;
          end else begin
            res_d = md_result;
          end
          state_d = S_WB;
        end else if (wd_q == WD_LAST) begin
          // Unit never answered: complete as an exception.
          res_d     = w_exc_code;
          pend_rd_d = EXC_RD;
          state_d   = S_WB;
        end
      end
      S_WB: begin
        if (!wb_pipe_valid) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Decode hazard detection against the pending destination and writeback drive.
  always_comb begin
    w_busy   = (state_q != S_IDLE);
    w_hazard = (pend_rd_q != 5'd0) &&
               ((dec_rs == pend_rd_q) || (dec_rt == pend_rd_q) ||
                (dec_writes && (dec_rd == pend_rd_q)));
    stall    = w_busy && (issue_valid || w_hazard);
    rf_we    = (state_q == S_WB) && !wb_pipe_valid && (pend_rd_q != 5'd0);
    rf_rd    = (state_q == S_WB) ? pend_rd_q : 5'd0;
    rf_data  = (state_q == S_WB) ? res_q : 32'd0;
  end

  assign busy         = w_busy;
  assign md_ctrl_mult = ctrl_mult_q;
  assign md_ctrl_div  = ctrl_div_q;
  assign md_a         = a_q;
  assign md_b         = b_q;

endmodule
`default_nettype wire

// File: tb/tb_multdiv_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_multdiv_sched
// Purpose  : Self-checking bench for multdiv_sched with a transaction-level
//            expectation model (directed cases plus randomized ops).
// Revision : 1.0 - initial release
// ============================================================================
module tb_multdiv_sched;

  localparam int TO = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        issue_valid = 1'b0;
  logic        issue_is_mult = 1'b0;
  logic [4:0]  issue_rd = 5'd0;
  logic [31:0] issue_a = 32'd0;
  logic [31:0] issue_b = 32'd0;
  logic [4:0]  dec_rs = 5'd0;
  logic [4:0]  dec_rt = 5'd0;
  logic [4:0]  dec_rd = 5'd0;
  logic        dec_writes = 1'b0;
  logic        stall;
  logic        md_ctrl_mult;
  logic        md_ctrl_div;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic [31:0] md_result = 32'd0;
  logic        md_ready = 1'b0;
  logic        md_exception = 1'b0;
  logic        wb_pipe_valid = 1'b0;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;
  logic        busy;

  multdiv_sched #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_is_mult(issue_is_mult), .issue_rd(issue_rd),
    .issue_a(issue_a), .issue_b(issue_b),
    .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_rd(dec_rd), .dec_writes(dec_writes),
    .stall(stall), .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
    .md_a(md_a), .md_b(md_b), .md_result(md_result), .md_ready(md_ready),
    .md_exception(md_exception), .wb_pipe_valid(wb_pipe_valid),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data), .busy(busy)
  );

  always #5 clock = ~clock;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] cur_a = 32'd0;
  logic [31:0] cur_b = 32'd0;
  bit          rnd_dec = 1'b0;
  bit          rnd_iss = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decode must hold while an op is outstanding and either another op is
  // offered or the decode instruction touches the pending destination.
  function automatic logic exp_stall(input logic bsy, input logic [4:0] pend);
    logic touch;
    touch = (dec_rs == pend) || (dec_rt == pend) || (dec_writes && dec_rd == pend);
    return bsy && (issue_valid || (pend != 5'd0 && touch));
  endfunction

  // One clock cycle: optional random decode traffic, checks mid-cycle, then advance.
  task automatic cyc(input string ph, input logic eb, input logic [4:0] pend,
                     input logic em, input logic ed, input logic inwb, input logic ewe,
                     input logic [4:0] erd, input logic [31:0] edata);
    if (rnd_dec) begin
      dec_rs     = ($urandom_range(0, 3) == 0) ? pend : 5'($urandom);
      dec_rt     = ($urandom_range(0, 3) == 0) ? pend : 5'($urandom);
      dec_rd     = ($urandom_range(0, 2) == 0) ? pend : 5'($urandom);
      dec_writes = 1'($urandom);
    end
    if (rnd_iss && eb && $urandom_range(0, 3) == 0) issue_valid = 1'b1;
    #3;
    chk({ph, ":busy"}, busy, eb);
    chk({ph, ":stall"}, stall, exp_stall(eb, pend));
    chk({ph, ":md_ctrl_mult"}, md_ctrl_mult, em);
    chk({ph, ":md_ctrl_div"}, md_ctrl_div, ed);
    chk({ph, ":md_a"}, md_a, cur_a);
    chk({ph, ":md_b"}, md_b, cur_b);
    chk({ph, ":rf_we"}, rf_we, ewe);
    if (inwb) begin
      chk({ph, ":rf_rd"}, rf_rd, erd);
      chk({ph, ":rf_data"}, rf_data, edata);
    end
    @(posedge clock);
    #1;
    issue_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string ph);
    chk({ph, ":busy"}, busy, 0);
    chk({ph, ":stall"}, stall, 0);
    chk({ph, ":md_ctrl_mult"}, md_ctrl_mult, 0);
    chk({ph, ":md_ctrl_div"}, md_ctrl_div, 0);
    chk({ph, ":md_a"}, md_a, 0);
    chk({ph, ":md_b"}, md_b, 0);
    chk({ph, ":rf_we"}, rf_we, 0);
    chk({ph, ":rf_rd"}, rf_rd, 0);
    chk({ph, ":rf_data"}, rf_data, 0);
  endtask

  // One complete op. dly = cycles from the start pulse to md_ready; 0 = never ready.
  task automatic op(input logic is_mult, input logic [4:0] rd, input logic [31:0] a,
                    input logic [31:0] b, input logic [31:0] res, input int dly,
                    input logic exc, input int nblk);
    logic [4:0]  erd;
    logic [31:0] edat;
    logic        fault;
    fault = (dly == 0) || exc;
    erd   = fault ? 5'd30 : rd;
    edat  = fault ? (is_mult ? 32'd4 : 32'd5) : res;
    // IDLE cycle carrying the issue
    issue_valid = 1'b1; issue_is_mult = is_mult; issue_rd = rd; issue_a = a; issue_b = b;
    cyc("idle", 0, rd, 0, 0, 0, 0, 0, 0);
    cur_a = a; cur_b = b;
    issue_a = $urandom; issue_b = $urandom; issue_rd = 5'($urandom); issue_is_mult = 1'($urandom);
    // START: a ready here must be ignored
    md_ready = 1'($urandom); md_result = $urandom; md_exception = 1'($urandom);
    cyc("start", 1, rd, is_mult, !is_mult, 0, 0, 0, 0);
    md_ready = 1'b0;
    if (dly == 0) begin
      for (int k = 1; k <= TO; k++) begin
        md_exception = 1'($urandom);
        cyc("run_to", 1, rd, 0, 0, 0, 0, 0, 0);
      end
    end else begin
      for (int k = 1; k < dly; k++) begin
        md_exception = 1'($urandom);
        cyc("run", 1, rd, 0, 0, 0, 0, 0, 0);
      end
      md_ready = 1'b1; md_result = res; md_exception = exc;
      cyc("ready", 1, rd, 0, 0, 0, 0, 0, 0);
      md_ready = 1'b0; md_result = $urandom; md_exception = 1'($urandom);
    end
    for (int k = 0; k < nblk; k++) begin
      wb_pipe_valid = 1'b1;
      cyc("wb_wait", 1, erd, 0, 0, 1, 0, erd, edat);
    end
    wb_pipe_valid = 1'b0;
    cyc("wb", 1, erd, 0, 0, 1, (erd != 5'd0), erd, edat);
    wb_pipe_valid = 1'($urandom);
    cyc("post", 0, erd, 0, 0, 0, 0, 0, 0);
    wb_pipe_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk_all_zero("reset");
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Mult 7*6 -> r5, ready 4 cycles after the pulse, port free
    dec_rs = 5'd1; dec_rt = 5'd2; dec_rd = 5'd3; dec_writes = 1'b0;
    op(1'b1, 5'd5, 32'd7, 32'd6, 32'd42, 4, 1'b0, 0);

    // Div exception to r30 code 5, then mult exception code 4
    op(1'b0, 5'd8, 32'd100, 32'd0, 32'd0, 3, 1'b1, 0);
    op(1'b1, 5'd8, 32'h7fffffff, 32'd2, 32'd0, 2, 1'b1, 0);

    // RAW hazard on r9, then unrelated decode with no write
    dec_rs = 5'd9; dec_rt = 5'd0; dec_rd = 5'd0; dec_writes = 1'b0;
    op(1'b1, 5'd9, 32'd3, 32'd3, 32'd9, 2, 1'b0, 0);
    dec_rs = 5'd10; dec_rt = 5'd11; dec_rd = 5'd9; dec_writes = 1'b0;
    op(1'b0, 5'd9, 32'd12, 32'd4, 32'd3, 3, 1'b0, 0);
    // WAW on the pending destination
    dec_rs = 5'd1; dec_rt = 5'd2; dec_rd = 5'd12; dec_writes = 1'b1;
    op(1'b1, 5'd12, 32'd5, 32'd5, 32'd25, 1, 1'b0, 0);

    // Port contention for 3 cycles
    op(1'b1, 5'd7, 32'd2, 32'd9, 32'd18, 2, 1'b0, 3);

    // rd = 0: no write, no hazard stall; second issue while busy stalls
    dec_rs = 5'd0; dec_rt = 5'd0; dec_rd = 5'd0; dec_writes = 1'b1;
    rnd_iss = 1'b1;
    op(1'b0, 5'd0, 32'd10, 32'd2, 32'd5, 5, 1'b0, 1);
    rnd_iss = 1'b0;

    // Timeout on a div
    op(1'b0, 5'd14, 32'd1, 32'd1, 32'd1, 0, 1'b0, 0);

    // Asynchronous reset during RUN
    issue_valid = 1'b1; issue_is_mult = 1'b1; issue_rd = 5'd6;
    issue_a = 32'hdead; issue_b = 32'hbeef;
    cyc("rst_idle", 0, 5'd6, 0, 0, 0, 0, 0, 0);
    cur_a = 32'hdead; cur_b = 32'hbeef;
    cyc("rst_start", 1, 5'd6, 1, 0, 0, 0, 0, 0);
    cyc("rst_run", 1, 5'd6, 0, 0, 0, 0, 0, 0);
    md_ready = 1'b1; md_result = 32'h1234; md_exception = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("async_rst");
    cur_a = 32'd0; cur_b = 32'd0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      md_exception = 1'($urandom);
      cyc("after_rst", 0, 5'd6, 0, 0, 0, 0, 0, 0);
    end
    md_ready = 1'b0;

    // Randomized ops with random decode traffic
    rnd_dec = 1'b1;
    rnd_iss = 1'b1;
    for (int n = 0; n < 40; n++) begin
      logic [4:0] r;
      int         d;
      r = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      d = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, TO - 1));
      op(1'($urandom), r, $urandom, $urandom, $urandom, d,
         ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Absolute bound so the run always ends even if something stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within bound");
    $fatal(1, "time limit reached");
  end

endmodule
`default_nettype wire
